// File: rtl/xor_pkg.sv
// +----------------------------------------------------------------------------+
// | xor_pkg: mode encoding shared by the conditional-invert/negate/XOR path.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package xor_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_PASS = 2'b00;
    localparam mode_t MODE_INV  = 2'b01;
    localparam mode_t MODE_NEG  = 2'b10;
    localparam mode_t MODE_XOR  = 2'b11;

endpackage : xor_pkg

`default_nettype wire

// File: rtl/word_xor.sv
// +----------------------------------------------------------------------------+
// | word_xor: combinational bitwise a ^ mask, reusable by ALU operand paths.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module word_xor #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] mask,
    output logic [WIDTH-1:0] y
);

    assign y = a ^ mask;

endmodule : word_xor

`default_nettype wire

// File: rtl/xor_neg_pipe.sv
// +----------------------------------------------------------------------------+
// | xor_neg_pipe: two-stage PASS/INV/NEG/XOR unit with valid/ready and flags.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module xor_neg_pipe
    import xor_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_parity,
    output logic             out_carry,
    output logic             out_ovf
);

    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    // Stage 1 state
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_x_q,     s1_x_d;
    logic             s1_inc_q,   s1_inc_d;
    logic             s1_ovf_q,   s1_ovf_d;

    // Stage 2 state (drives the outputs directly)
    logic             s2_valid_q,  s2_valid_d;
    logic [WIDTH-1:0] s2_data_q,   s2_data_d;
    logic             s2_zero_q,   s2_zero_d;
    logic             s2_parity_q, s2_parity_d;
    logic             s2_carry_q,  s2_carry_d;
    logic             s2_ovf_q,    s2_ovf_d;

    logic             s2_load;
    logic             s1_adv;
    mode_t            mode;
    logic [WIDTH-1:0] mask;
    logic [WIDTH-1:0] x_in;
    logic [WIDTH:0]   sum;

    assign mode    = mode_t'(in_mode);
    assign s2_load = !s2_valid_q || out_ready;
    assign s1_adv  = !s1_valid_q || s2_load;
    assign in_ready = s1_adv && !rst;

    always_comb begin
        mask = '0;
        case (mode)
            MODE_INV, MODE_NEG: mask = '1;
            MODE_XOR:           mask = in_b;
            default:            mask = '0;
        endcase
    end

    word_xor #(
        .WIDTH (WIDTH)
    ) u_word_xor (
        .a    (in_a),
        .mask (mask),
        .y    (x_in)
    );

    // Carry can only be set by the NEG increment since a zero addend never carries.
    assign sum = {1'b0, s1_x_q} + {{WIDTH{1'b0}}, s1_inc_q};

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_x_d     = s1_x_q;
        s1_inc_d   = s1_inc_q;
        s1_ovf_d   = s1_ovf_q;
        if (s1_adv) begin
            s1_valid_d = in_valid;
            s1_x_d     = x_in;
            s1_inc_d   = (mode == MODE_NEG);
            s1_ovf_d   = (mode == MODE_NEG) && (in_a == MOST_NEG);
        end
    end

    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_data_d   = s2_data_q;
        s2_zero_d   = s2_zero_q;
        s2_parity_d = s2_parity_q;
        s2_carry_d  = s2_carry_q;
        s2_ovf_d    = s2_ovf_q;
        if (s2_load) begin
            s2_valid_d  = s1_valid_q;
            s2_data_d   = sum[WIDTH-1:0];
            s2_zero_d   = (sum[WIDTH-1:0] == '0);
            s2_parity_d = ^sum[WIDTH-1:0];
            s2_carry_d  = sum[WIDTH];
            s2_ovf_d    = s1_ovf_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_inc_q    <= 1'b0;
            s1_ovf_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
            s2_zero_q   <= 1'b0;
            s2_parity_q <= 1'b0;
            s2_carry_q  <= 1'b0;
            s2_ovf_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_inc_q    <= s1_inc_d;
            s1_ovf_q    <= s1_ovf_d;
            s2_valid_q  <= s2_valid_d;
            s2_data_q   <= s2_data_d;
            s2_zero_q   <= s2_zero_d;
            s2_parity_q <= s2_parity_d;
            s2_carry_q  <= s2_carry_d;
            s2_ovf_q    <= s2_ovf_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_data   = s2_data_q;
    assign out_zero   = s2_zero_q;
    assign out_parity = s2_parity_q;
    assign out_carry  = s2_carry_q;
    assign out_ovf    = s2_ovf_q;

endmodule : xor_neg_pipe

`default_nettype wire

// File: tb/tb_xor_neg_pipe.sv
// +----------------------------------------------------------------------------+
// | tb_xor_neg_pipe: vector table, scoreboard and corner-case sequences.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_xor_neg_pipe;
    import xor_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] in_mode = 2'b00;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_zero, out_parity, out_carry, out_ovf;

    xor_neg_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_zero(out_zero), .out_parity(out_parity),
        .out_carry(out_carry), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] data;
        logic       zero;
        logic       parity;
        logic       carry;
        logic       ovf;
    } res_t;

    typedef struct {
        mode_t      m;
        logic [7:0] a;
        logic [7:0] b;
        res_t       r;
    } vec_t;

    res_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    // Reference written arithmetically: negate as 0 - a, carry when a == 0.
    function automatic res_t model(input mode_t m, input logic [7:0] a, input logic [7:0] b);
        res_t r;
        r = '0;
        case (m)
            MODE_PASS: r.data = a;
            MODE_INV:  r.data = 8'hFF - a;
            MODE_NEG: begin
                r.data  = 8'(9'h100 - {1'b0, a});
                r.carry = (a == 8'h00);
                r.ovf   = (a == 8'h80);
            end
            default:   r.data = a ^ b;
        endcase
        r.zero   = (r.data == 8'h00);
        r.parity = ^r.data;
        return r;
    endfunction

    // One clock cycle: drive at negedge, decide handshakes after settling.
    task automatic cycle(input logic v, input mode_t m, input logic [7:0] a, input logic [7:0] b,
                         input logic ordy, input res_t e, output logic acc, output logic dlv);
        res_t got, exp_r;
        @(negedge clk);
        in_valid  = v;
        in_mode   = m;
        in_a      = a;
        in_b      = b;
        out_ready = ordy;
        #1;
        dlv = out_valid && out_ready;
        if (dlv) begin
            got = '{out_data, out_zero, out_parity, out_carry, out_ovf};
            if (q.size() == 0) begin
                check("unexpected_beat", {24'd0, got.data}, 32'hFFFF_FFFF);
            end else begin
                exp_r = q.pop_front();
                check("result", {19'd0, got}, {19'd0, exp_r});
            end
        end
        acc = in_valid && in_ready;
        if (acc) q.push_back(e);
    endtask

    task automatic drain();
        logic acc, dlv;
        for (int i = 0; i < 10 && q.size() != 0; i++)
            cycle(1'b0, MODE_PASS, 8'h00, 8'h00, 1'b1, '0, acc, dlv);
        check("drain_empty", q.size(), 0);
    endtask

    initial begin
        vec_t       vecs[8];
        logic       acc, dlv;
        int         nd, first_d, last_d, nacc;
        logic [7:0] seen[3];
        int         ns;
        mode_t      rm;
        logic [7:0] ra, rb;

        vecs[0] = '{MODE_NEG,  8'h00, 8'h00, '{8'h00, 1'b1, 1'b0, 1'b1, 1'b0}};
        vecs[1] = '{MODE_NEG,  8'h80, 8'h00, '{8'h80, 1'b0, 1'b1, 1'b0, 1'b1}};
        vecs[2] = '{MODE_NEG,  8'h05, 8'h00, '{8'hFB, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[3] = '{MODE_INV,  8'hA5, 8'h00, '{8'h5A, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[4] = '{MODE_XOR,  8'hF0, 8'h3C, '{8'hCC, 1'b0, 1'b0, 1'b0, 1'b0}};
        vecs[5] = '{MODE_PASS, 8'h01, 8'h77, '{8'h01, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[6] = '{MODE_NEG,  8'hFF, 8'h00, '{8'h01, 1'b0, 1'b1, 1'b0, 1'b0}};
        vecs[7] = '{MODE_INV,  8'hFF, 8'h00, '{8'h00, 1'b1, 1'b0, 1'b0, 1'b0}};

        // Reset state
        in_valid = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_flags", {out_zero, out_parity, out_carry, out_ovf}, 0);
        check("rst_in_ready", in_ready, 0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Vector table, one beat each then drained
        foreach (vecs[i]) begin
            cycle(1'b1, vecs[i].m, vecs[i].a, vecs[i].b, 1'b1, vecs[i].r, acc, dlv);
            check("vec_accept", acc, 1);
            drain();
        end

        // Backpressure: two accepted, third held off until out_ready rises
        cycle(1'b1, MODE_PASS, 8'h11, 8'h00, 1'b0, model(MODE_PASS, 8'h11, 8'h00), acc, dlv);
        check("bp_acc0", acc, 1);
        cycle(1'b1, MODE_PASS, 8'h22, 8'h00, 1'b0, model(MODE_PASS, 8'h22, 8'h00), acc, dlv);
        check("bp_acc1", acc, 1);
        for (int i = 0; i < 2; i++) begin
            cycle(1'b1, MODE_PASS, 8'h33, 8'h00, 1'b0, model(MODE_PASS, 8'h33, 8'h00), acc, dlv);
            check("bp_full_in_ready", in_ready, 0);
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_data", out_data, 32'h11);
        end
        ns = 0;
        cycle(1'b1, MODE_PASS, 8'h33, 8'h00, 1'b1, model(MODE_PASS, 8'h33, 8'h00), acc, dlv);
        check("bp_acc2", acc, 1);
        if (dlv) begin seen[ns] = out_data; ns++; end
        for (int i = 0; i < 2; i++) begin
            cycle(1'b0, MODE_PASS, 8'h00, 8'h00, 1'b1, '0, acc, dlv);
            if (dlv && ns < 3) begin seen[ns] = out_data; ns++; end
        end
        check("bp_consecutive", ns, 3);
        check("bp_order", {seen[0], seen[1], seen[2]}, 32'h112233);
        drain();

        // Streaming: 16 random beats, full throughput
        nd = 0; first_d = -1; last_d = -1; nacc = 0;
        for (int c = 0; c < 22; c++) begin
            rm = mode_t'($urandom_range(0, 3));
            ra = 8'($urandom);
            rb = 8'($urandom);
            cycle(c < 16, rm, ra, rb, 1'b1, model(rm, ra, rb), acc, dlv);
            if (acc) nacc++;
            if (dlv) begin
                if (first_d < 0) first_d = c;
                last_d = c;
                nd++;
            end
        end
        check("stream_accepted", nacc, 16);
        check("stream_delivered", nd, 16);
        check("stream_first_latency", first_d, 2);
        check("stream_contiguous", last_d - first_d, 15);
        drain();

        // Reset mid-stream with both stages full
        cycle(1'b1, MODE_PASS, 8'h44, 8'h00, 1'b0, model(MODE_PASS, 8'h44, 8'h00), acc, dlv);
        cycle(1'b1, MODE_PASS, 8'h55, 8'h00, 1'b0, model(MODE_PASS, 8'h55, 8'h00), acc, dlv);
        @(negedge clk);
        #1;
        check("full_before_rst", {out_valid, in_ready}, 2'b10);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_in_ready", in_ready, 0);
        q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_release_ready", in_ready, 1);
        cycle(1'b1, MODE_NEG, 8'h03, 8'h00, 1'b1, model(MODE_NEG, 8'h03, 8'h00), acc, dlv);
        check("post_rst_accept", acc, 1);
        check("post_rst_no_stale", dlv, 0);
        cycle(1'b0, MODE_PASS, 8'h00, 8'h00, 1'b1, '0, acc, dlv);
        check("post_rst_lat1", out_valid, 0);
        cycle(1'b0, MODE_PASS, 8'h00, 8'h00, 1'b1, '0, acc, dlv);
        check("post_rst_lat2", dlv, 1);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running required finished");
        $fatal(1);
    end

endmodule : tb_xor_neg_pipe

`default_nettype wire
